// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer beside EXE; owns the HI/LO registers.
// One shift-add or restoring-subtract iteration per cycle, then a sign fix-up cycle.
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_req,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_result
);

    localparam logic [2:0] OP_MFHI = 3'b100;
    localparam logic [2:0] OP_MFLO = 3'b101;
    localparam logic [2:0] OP_MTHI = 3'b110;
    localparam logic [2:0] OP_MTLO = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    typedef struct packed {
        logic is_div;
        logic q_neg;   // product sign for multiply, quotient sign for divide
        logic r_neg;
        logic dz;
    } ctx_t;

    state_t             state;
    ctx_t               ctx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    // Operand conditioning at the start edge
    logic             op_signed;
    logic [WIDTH-1:0] abs_a, abs_b;
    assign op_signed = ~i_op[0];
    assign abs_a = (op_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign abs_b = (op_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // Multiply step: acc = {partial, multiplier}; add multiplicand on LSB then shift right
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide step: acc = {remainder, dividend/quotient}
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_next  = div_diff[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    // Two's-complement sign fix applied in FIXUP
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   rem_fix, quot_fix, fix_hi, fix_lo;
    assign prod_fix = ctx.q_neg ? -acc : acc;
    assign rem_fix  = ctx.r_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign quot_fix = ctx.q_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign fix_hi   = ctx.is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = ctx.is_div ? (ctx.dz ? {WIDTH{1'b1}} : quot_fix) : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            ctx    <= '0;
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req && !i_flush) begin
                        if (!i_op[2]) begin
                            ctx.is_div <= i_op[1];
                            ctx.q_neg  <= op_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                            ctx.r_neg  <= op_signed & i_a[WIDTH-1];
                            ctx.dz     <= i_op[1] & (i_b == '0);
                            cnt        <= CNT_W'(WIDTH-1);
                            state      <= CALC;
                            if (i_op[1]) begin
                                opnd <= abs_b;
                                // Divide by zero parks |a| in the remainder half and holds it
                                acc  <= (i_b == '0) ? {abs_a, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, abs_a};
                            end else begin
                                opnd <= abs_a;
                                acc  <= {{WIDTH{1'b0}}, abs_b};
                            end
                        end else if (i_op == OP_MTHI) begin
                            hi_q <= i_a;
                        end else if (i_op == OP_MTLO) begin
                            lo_q <= i_a;
                        end
                    end
                end
                CALC: begin
                    if (i_flush) begin
                        state <= IDLE;
                    end else begin
                        if (!ctx.dz)
                            acc <= ctx.is_div ? div_next : mul_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0)
                            state <= FIXUP;
                    end
                end
                FIXUP: begin
                    state <= IDLE;
                    if (!i_flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_stall = o_busy & i_req;
    assign o_done  = done_q;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_MFHI: o_result = hi_q;
            OP_MFLO: o_result = lo_q;
            default: o_result = '0;
        endcase
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO queued at issue, checked on o_done.
module tb_muldiv_ctrl;
    localparam int W = 32;
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                           MFHI = 3'd4, MFLO = 3'd5, MTHI = 3'd6, MTLO = 3'd7;

    logic         clk = 1'b0, rstn = 1'b0;
    logic         i_req = 1'b0, i_flush = 1'b0;
    logic [2:0]   i_op = 3'd0;
    logic [W-1:0] i_a = '0, i_b = '0;
    logic         o_busy, o_stall, o_done;
    logic [W-1:0] o_hi, o_lo, o_result;

    int total = 0, bad = 0, done_cnt = 0;
    logic [63:0]  sb_q[$];
    logic [W-1:0] hi_m = '0, lo_m = '0;

    muldiv_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rstn(rstn), .i_req(i_req), .i_op(i_op), .i_a(i_a), .i_b(i_b),
        .i_flush(i_flush), .o_busy(o_busy), .o_stall(o_stall), .o_done(o_done),
        .o_hi(o_hi), .o_lo(o_lo), .o_result(o_result));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        case (op)
            MULT: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                return p;
            end
            MULTU: return {32'b0, a} * {32'b0, b};
            DIV: begin
                if (b == '0) return {a, 32'hFFFF_FFFF};
                sa = longint'($signed(a)); sb = longint'($signed(b));
                q = sa / sb; r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == '0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (rstn && o_done) begin
            logic [63:0] e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("hi", {32'b0, o_hi}, {32'b0, e[63:32]});
                chk("lo", {32'b0, o_lo}, {32'b0, e[31:0]});
                hi_m = e[63:32];
                lo_m = e[31:0];
            end
        end
    end

    // Issue one op; returns at the negedge after the start edge with operands scrambled
    task automatic start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(negedge clk);
        i_req = 1'b1; i_op = op; i_a = a; i_b = b;
        if (push) sb_q.push_back(model(op, a, b));
        @(negedge clk);
        i_req = 1'b0; i_a = $urandom; i_b = $urandom;
    endtask

    task automatic wait_done(output int nbusy, output int nstall);
        int n;
        nbusy = 0; nstall = 0; n = 0;
        while (!o_done && n < 60) begin
            if (o_busy) nbusy++;
            if (o_stall) nstall++;
            @(negedge clk);
            n++;
        end
        if (!o_done) chk("timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int nb, ns;
        start(op, a, b, 1'b1);
        wait_done(nb, ns);
        @(negedge clk);
    endtask

    initial begin
        int nb, ns, d0;
        #1;
        chk("rst_busy", {63'b0, o_busy}, 64'd0);
        chk("rst_done", {63'b0, o_done}, 64'd0);
        chk("rst_hi", {32'b0, o_hi}, 64'd0);
        chk("rst_lo", {32'b0, o_lo}, 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        start(MULT, 32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done(nb, ns);
        chk("mult_busy_cycles", 64'(nb), 64'd33);
        chk("mult_done_pulse", {63'b0, o_done}, 64'd1);
        @(negedge clk);
        chk("done_one_cycle", {63'b0, o_done}, 64'd0);

        run(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(DIVU, 32'd100, 32'd7);
        run(DIV, 32'hFFFF_FFF9, 32'd2);
        run(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        start(DIVU, 32'h1234, 32'd0, 1'b1);
        wait_done(nb, ns);
        chk("dz_busy_cycles", 64'(nb), 64'd33);
        @(negedge clk);
        run(DIV, 32'hFFFF_FF00, 32'd0);
        run(DIV, 32'd9, 32'hFFFF_FFFC);
        for (int k = 0; k < 6; k++)
            run(3'($urandom_range(0, 3)), $urandom, (k == 3) ? 32'd0 : $urandom);

        // MFHI held across a divide stalls every busy cycle, then reads the new HI
        start(DIV, 32'd1000, 32'hFFFF_FFFD, 1'b1);
        i_req = 1'b1; i_op = MFHI;
        wait_done(nb, ns);
        chk("stall_cycles", 64'(ns), 64'd33);
        chk("stall_after_done", {63'b0, o_stall}, 64'd0);
        chk("mfhi_new", {32'b0, o_result}, {32'b0, model(DIV, 32'd1000, 32'hFFFF_FFFD) >> 32});
        i_op = MFLO; #1;
        chk("mflo_new", {32'b0, o_result}, 64'(model(DIV, 32'd1000, 32'hFFFF_FFFD) & 64'hFFFF_FFFF));
        @(negedge clk); i_req = 1'b0;

        // MTLO held while busy only lands once the unit is idle
        start(MULTU, 32'd3, 32'd4, 1'b1);
        i_req = 1'b1; i_op = MTLO; i_a = 32'hABCD;
        wait_done(nb, ns);
        @(negedge clk);
        i_req = 1'b0;
        chk("mtlo_reissued", {32'b0, o_lo}, 64'hABCD);
        chk("mtlo_hi_kept", {32'b0, o_hi}, 64'd0);
        lo_m = 32'hABCD;

        @(negedge clk);
        i_req = 1'b1; i_op = MTHI; i_a = 32'h1357_9BDF;
        @(negedge clk);
        i_req = 1'b0; hi_m = 32'h1357_9BDF;
        chk("mthi", {32'b0, o_hi}, {32'b0, hi_m});

        // Flush mid-CALC
        d0 = done_cnt;
        start(DIVU, 32'd50000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("flush_idle", {63'b0, o_busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_hi", {32'b0, o_hi}, {32'b0, hi_m});
        chk("flush_lo", {32'b0, o_lo}, {32'b0, lo_m});
        chk("flush_nodone", 64'(done_cnt - d0), 64'd0);

        // Flush coincident with FIXUP
        start(MULTU, 32'd77, 32'd99, 1'b0);
        repeat (32) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("fixup_flush_idle", {63'b0, o_busy}, 64'd0);
        chk("fixup_flush_done", {63'b0, o_done}, 64'd0);
        chk("fixup_flush_lo", {32'b0, o_lo}, {32'b0, lo_m});

        // Flush in IDLE kills an MTHI
        i_req = 1'b1; i_op = MTHI; i_a = 32'h5555; i_flush = 1'b1;
        @(negedge clk);
        i_req = 1'b0; i_flush = 1'b0;
        chk("idle_flush_mthi", {32'b0, o_hi}, {32'b0, hi_m});

        // Asynchronous reset mid-CALC
        start(MULT, 32'd123, 32'd456, 1'b0);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_mid_busy", {63'b0, o_busy}, 64'd0);
        chk("rst_mid_hi", {32'b0, o_hi}, 64'd0);
        chk("rst_mid_lo", {32'b0, o_lo}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_mid_nodone", {63'b0, o_done}, 64'd0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer beside the EXE stage; owns the HI/LO architectural registers.
- Accepts MULT/MULTU/DIV/DIVU from EXE and runs a 32-iteration shift-add or restoring-divide loop.
- Services MFHI/MFLO/MTHI/MTLO.
- Drives a stall to the pipeline while a requester needs a busy unit; aborts on branch flush.

Parameters:
- WIDTH, 32, operand/HI/LO width; also the iteration count.
- CNT_W, 5, iteration counter width, equal to log2(WIDTH).

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- i_req  input  1  EXE holds a valid mul/div/HI-LO instruction this cycle
- i_op  input  3  opcode: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO
- i_a  input  WIDTH  rs operand (multiplicand/dividend/MT source)
- i_b  input  WIDTH  rt operand (multiplier/divisor)
- i_flush  input  1  branch clear from EXE; aborts in-flight operation
- o_busy  output  1  state != IDLE
- o_stall  output  1  o_busy & i_req, combinational
- o_done  output  1  one-cycle pulse when HI/LO updated by mul/div
- o_hi  output  WIDTH  HI register
- o_lo  output  WIDTH  LO register
- o_result  output  WIDTH  combinational: HI for MFHI, LO for MFLO, else 0

Behaviour:
- Reset: state IDLE, HI=LO=0, counter=0, o_busy=0, o_done=0, internal accumulators 0. Reset mid-operation discards the operation immediately.
- States: IDLE, CALC, FIXUP.
- IDLE, i_req, op 0xx, !i_flush:
  - Latch |a| and |b| (signed ops) or raw values (unsigned).
  - Latch the result-sign bits: MULT: a^b; DIV: quotient a^b, remainder a.
  - counter=WIDTH-1; go to CALC.
- IDLE, i_req, MTHI/MTLO, !i_flush: write HI/LO from i_a at the edge; stay IDLE; no o_done.
- MFHI/MFLO: purely combinational via o_result; no state change.
- CALC, multiply: one shift-add per cycle over a 2*WIDTH product.
- CALC, divide: one restoring subtract per cycle over the remainder and quotient.
- CALC exit: counter decrements each cycle; at counter==0 go to FIXUP.
- FIXUP: apply two's-complement sign fix, write HI/LO, pulse o_done, go to IDLE.
- Latency: start edge E0; CALC occupies E1..E32; HI/LO written and o_done high after E33. o_busy is high for 33 cycles.
- Multiply result: HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide result: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- Divide by zero, signed and unsigned: LO=0xFFFFFFFF, HI=i_a unchanged. Same 34-cycle latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Requests while busy (any op) are not executed. o_stall holds EXE until o_busy falls.
- MFHI/MFLO in the cycle after o_done reads the new values.
- A request with i_req held across the stall issues in the first IDLE cycle.
- i_flush while busy: next edge goes to IDLE, HI/LO unchanged, no o_done.
- i_flush coincident with FIXUP: flush wins; no write.
- i_flush with i_req in IDLE: request ignored, including MTHI/MTLO.
- Operand inputs are sampled only at the start edge; later changes have no effect.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> after 34 edges o_done=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1; o_busy high exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234.
- MFHI with i_req held during a DIV -> o_stall=1 every busy cycle. Cycle after o_done: o_stall=0, o_result = new HI. MTLO 0xABCD while busy -> LO unchanged until reissued.
- i_flush at CALC cycle 10 -> IDLE next edge, HI/LO keep prior values, no o_done.
- rstn low mid-CALC -> immediate IDLE, HI=LO=0.
